// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals of the two-requester ALU arbiter.
// slave: arbiter side; master: client/ALU side.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [2:0]              req_opcode0;
    logic [2:0]              req_opcode1;
    logic [DATA_WIDTH-1:0]   req_a0;
    logic [DATA_WIDTH-1:0]   req_a1;
    logic [DATA_WIDTH-1:0]   req_b0;
    logic [DATA_WIDTH-1:0]   req_b1;
    logic [2:0]              alu_opcode;
    logic [DATA_WIDTH-1:0]   alu_portA;
    logic [DATA_WIDTH-1:0]   alu_portB;
    logic [2*DATA_WIDTH-1:0] alu_out;
    logic                    alu_carry;
    logic                    alu_zero;
    logic [1:0]              rsp_valid;
    logic [2*DATA_WIDTH-1:0] rsp_result;
    logic                    rsp_carry;
    logic                    rsp_zero;
    logic                    busy;

    modport slave (
        input  req_valid, req_opcode0, req_opcode1, req_a0, req_a1, req_b0, req_b1,
        input  alu_out, alu_carry, alu_zero,
        output req_ready, alu_opcode, alu_portA, alu_portB,
        output rsp_valid, rsp_result, rsp_carry, rsp_zero, busy
    );

    modport master (
        output req_valid, req_opcode0, req_opcode1, req_a0, req_a1, req_b0, req_b1,
        output alu_out, alu_carry, alu_zero,
        input  req_ready, alu_opcode, alu_portA, alu_portB,
        input  rsp_valid, rsp_result, rsp_carry, rsp_zero, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Optional ALU_ARB_STATS_EN adds saturating per-requester accept counters.
//
// state | meaning
// IDLE  | arbitrating; req_ready driven combinationally
// EXEC  | ALU inputs held, latency counter running
// RESP  | rsp_valid pulsed to the owner for one cycle
module alu_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk_arb,
    input  logic        rst_n_arb,
    alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] stat_grant0,
    output logic [15:0] stat_grant1
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state, state_nxt;
    logic       owner;
    logic       last_grant;
    logic [3:0] cnt;
    logic [1:0] grant;
    logic       accept;

    // Gated by reset so req_ready reads 0 while reset is held.
    always_comb begin
        grant = 2'b00;
        if (rst_n_arb && state == IDLE) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign accept        = |grant;
    assign bus.req_ready = grant;
    assign bus.busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_arb or negedge rst_n_arb) begin
        if (!rst_n_arb) state <= IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge clk_arb or negedge rst_n_arb) begin
        if (!rst_n_arb) begin
            owner          <= 1'b0;
            last_grant     <= 1'b1;
            cnt            <= 4'd0;
            bus.alu_opcode <= 3'd0;
            bus.alu_portA  <= '0;
            bus.alu_portB  <= '0;
            bus.rsp_valid  <= 2'b00;
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_zero   <= 1'b0;
        end else begin
            bus.rsp_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner          <= grant[1];
                        last_grant     <= grant[1];
                        cnt            <= 4'(ALU_LATENCY);
                        bus.alu_opcode <= grant[1] ? bus.req_opcode1 : bus.req_opcode0;
                        bus.alu_portA  <= grant[1] ? bus.req_a1 : bus.req_a0;
                        bus.alu_portB  <= grant[1] ? bus.req_b1 : bus.req_b0;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        bus.rsp_result <= bus.alu_out;
                        bus.rsp_carry  <= bus.alu_carry;
                        bus.rsp_zero   <= bus.alu_zero;
                        bus.rsp_valid  <= owner ? 2'b10 : 2'b01;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk_arb or negedge rst_n_arb) begin
        if (!rst_n_arb) begin
            stat_grant0 <= 16'd0;
            stat_grant1 <= 16'd0;
        end else begin
            if (grant[0] && stat_grant0 != 16'hFFFF) stat_grant0 <= stat_grant0 + 16'd1;
            if (grant[1] && stat_grant1 != 16'hFFFF) stat_grant1 <= stat_grant1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: L=1 instance for function/fairness/reset,
// L=3 instance for latency timing.
module tb_alu_arbiter;
    typedef struct packed {
        logic        owner;
        logic [15:0] res;
        logic        c;
        logic        z;
    } exp_t;

    typedef struct {
        int          r;
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        c;
        logic        z;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [2:0] op0 = 3'd0, op1 = 3'd0;
    logic [7:0] a0 = 8'd0, a1 = 8'd0, b0 = 8'd0, b1 = 8'd0;
    int         checks = 0;
    int         passed = 0;
    int         cyc = 0;
    bit         sb_en = 1'b1;
    exp_t       sb[$];
    vec_t       vecs[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter_if #(.DATA_WIDTH(8)) if1 ();
    alu_arbiter_if #(.DATA_WIDTH(8)) if3 ();

    assign if1.req_valid = req_valid;   assign if3.req_valid = req_valid;
    assign if1.req_opcode0 = op0;       assign if3.req_opcode0 = op0;
    assign if1.req_opcode1 = op1;       assign if3.req_opcode1 = op1;
    assign if1.req_a0 = a0;             assign if3.req_a0 = a0;
    assign if1.req_a1 = a1;             assign if3.req_a1 = a1;
    assign if1.req_b0 = b0;             assign if3.req_b0 = b0;
    assign if1.req_b1 = b1;             assign if3.req_b1 = b1;

    function automatic exp_t alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t       r;
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        r.owner = 1'b0;
        r.c     = 1'b0;
        case (op)
            3'd0: begin r.res = {7'd0, s}; r.c = s[8]; end
            3'd2: r.res = a * b;
            default: r.res = {8'd0, a ^ b};
        endcase
        r.z = (r.res == 16'd0);
        return r;
    endfunction

    // ALU model: latency 1 is combinational on the registered ports; latency 3 adds two stages
    exp_t m1, m3, d1, d2;
    always_comb m1 = alu_f(if1.alu_opcode, if1.alu_portA, if1.alu_portB);
    always_comb m3 = alu_f(if3.alu_opcode, if3.alu_portA, if3.alu_portB);
    always @(posedge clk) begin d1 <= m3; d2 <= d1; end
    assign if1.alu_out = m1.res; assign if1.alu_carry = m1.c; assign if1.alu_zero = m1.z;
    assign if3.alu_out = d2.res; assign if3.alu_carry = d2.c; assign if3.alu_zero = d2.z;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] sg0, sg1, sg0_3, sg1_3;
`endif

    alu_arbiter #(.DATA_WIDTH(8), .ALU_LATENCY(1)) dut1 (
        .clk_arb(clk), .rst_n_arb(rst_n), .bus(if1)
`ifdef ALU_ARB_STATS_EN
        , .stat_grant0(sg0), .stat_grant1(sg1)
`endif
    );

    alu_arbiter #(.DATA_WIDTH(8), .ALU_LATENCY(3)) dut3 (
        .clk_arb(clk), .rst_n_arb(rst_n), .bus(if3)
`ifdef ALU_ARB_STATS_EN
        , .stat_grant0(sg0_3), .stat_grant1(sg1_3)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: each response on the L=1 instance is matched against the oldest pushed expectation
    always @(negedge clk) begin
        if (sb_en && if1.rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", {30'd0, if1.rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rsp_valid", {30'd0, if1.rsp_valid}, e.owner ? 32'd2 : 32'd1);
                chk("sb_rsp_result", {16'd0, if1.rsp_result}, {16'd0, e.res});
                chk("sb_rsp_carry", {31'd0, if1.rsp_carry}, {31'd0, e.c});
                chk("sb_rsp_zero", {31'd0, if1.rsp_zero}, {31'd0, e.z});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin @(negedge clk); #1; end
        chk("sb_drain", sb.size(), 0);
    endtask

    task automatic issue(input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] res, input logic c, input logic z);
        bit   got;
        exp_t e;
        @(negedge clk);
        if (r == 0) begin op0 = op; a0 = a; b0 = b; req_valid = 2'b01; end
        else        begin op1 = op; a1 = a; b1 = b; req_valid = 2'b10; end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (if1.req_ready == req_valid) got = 1'b1;
            else @(negedge clk);
        end
        chk("issue_grant", {31'd0, got}, 32'd1);
        if (got) begin
            e.owner = (r != 0); e.res = res; e.c = c; e.z = z;
            sb.push_back(e);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   gr[4];
        int   ta[4];
        int   n;
        exp_t e;

        vecs[0] = '{0, 3'd0, 8'd12,  8'd16,  16'd28,     1'b0, 1'b0};
        vecs[1] = '{1, 3'd0, 8'd255, 8'd1,   16'h0100,   1'b1, 1'b0};
        vecs[2] = '{0, 3'd2, 8'd127, 8'd127, 16'd16129,  1'b0, 1'b0};
        vecs[3] = '{1, 3'd5, 8'hAA,  8'hAA,  16'd0,      1'b0, 1'b1};
        vecs[4] = '{0, 3'd7, 8'h0F,  8'hF0,  16'h00FF,   1'b0, 1'b0};
        vecs[5] = '{1, 3'd2, 8'd255, 8'd255, 16'd65025,  1'b0, 1'b0};
        vecs[6] = '{0, 3'd0, 8'd0,   8'd0,   16'd0,      1'b0, 1'b1};
        vecs[7] = '{1, 3'd1, 8'd3,   8'd5,   16'd6,      1'b0, 1'b0};

        // reset state, with both requesters asserting valid
        req_valid = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", {30'd0, if1.req_ready}, 32'd0);
        chk("rst_busy", {31'd0, if1.busy}, 32'd0);
        chk("rst_rsp_valid", {30'd0, if1.rsp_valid}, 32'd0);
        chk("rst_alu_opcode", {29'd0, if1.alu_opcode}, 32'd0);
        chk("rst_alu_ports", {16'd0, if1.alu_portA, if1.alu_portB}, 32'd0);
        chk("rst_rsp_result", {16'd0, if1.rsp_result}, 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // single op, L=1
        @(negedge clk);
        op0 = 3'd0; a0 = 8'd12; b0 = 8'd16; req_valid = 2'b01;
        #1;
        chk("single_ready", {30'd0, if1.req_ready}, 32'd1);
        e.owner = 1'b0; e.res = 16'd28; e.c = 1'b0; e.z = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("single_portA", {24'd0, if1.alu_portA}, 32'd12);
        chk("single_portB", {24'd0, if1.alu_portB}, 32'd16);
        chk("single_busy_exec", {31'd0, if1.busy}, 32'd1);
        @(posedge clk); #1;
        chk("single_rsp_valid", {30'd0, if1.rsp_valid}, 32'd1);
        chk("single_rsp_result", {16'd0, if1.rsp_result}, 32'd28);
        @(posedge clk); #1;
        chk("single_rsp_clear", {30'd0, if1.rsp_valid}, 32'd0);
        chk("single_busy_idle", {31'd0, if1.busy}, 32'd0);
        drain();

        // tie after reset, then fairness over 4 ops
        do_reset();
        @(negedge clk);
        op0 = 3'd2; a0 = 8'd127; b0 = 8'd127;
        op1 = 3'd0; a1 = 8'd255; b1 = 8'd1;
        req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            #1;
            if (if1.req_ready != 2'b00) begin
                gr[n] = int'(if1.req_ready[1]);
                ta[n] = cyc;
                e.owner = if1.req_ready[1];
                if (if1.req_ready[1]) begin e.res = 16'd256;   e.c = 1'b1; end
                else                  begin e.res = 16'd16129; e.c = 1'b0; end
                e.z = 1'b0;
                sb.push_back(e);
                n++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("fair_count", n, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("fair_order%0d", i), gr[i], i % 2);
        for (int i = 1; i < 4; i++) chk($sformatf("fair_spacing%0d", i), ta[i] - ta[i-1], 3);
        drain();

        // table-driven ops
        for (int i = 0; i < 8; i++)
            issue(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].c, vecs[i].z);

        // L=3 timing on the second instance; requester 1 held pending throughout
        sb_en = 1'b0;
        do_reset();
        @(negedge clk);
        op0 = 3'd0; a0 = 8'd20; b0 = 8'd30; req_valid = 2'b01;
        #1;
        chk("l3_ready", {30'd0, if3.req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b10;
        chk("l3_busy_k", {31'd0, if3.busy}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("l3_rsp_valid_k%0d", i), {30'd0, if3.rsp_valid}, (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("l3_busy_k%0d", i), {31'd0, if3.busy}, (i < 4) ? 32'd1 : 32'd0);
            chk($sformatf("l3_ready_k%0d", i), {30'd0, if3.req_ready}, (i == 4) ? 32'd2 : 32'd0);
            if (i == 3) chk("l3_rsp_result", {16'd0, if3.rsp_result}, 32'd50);
        end
        req_valid = 2'b00;

        // reset during EXEC of a requester-0 op
        do_reset();
        @(negedge clk);
        op0 = 3'd3; a0 = 8'd1; b0 = 8'd2; req_valid = 2'b01;
        #1;
        chk("midrst_ready", {30'd0, if1.req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("midrst_busy_before", {31'd0, if1.busy}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, if1.busy}, 32'd0);
        chk("midrst_portA", {24'd0, if1.alu_portA}, 32'd0);
        chk("midrst_opcode", {29'd0, if1.alu_opcode}, 32'd0);
        chk("midrst_rsp_valid", {30'd0, if1.rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk($sformatf("midrst_no_rsp%0d", i), {30'd0, if1.rsp_valid}, 32'd0);
        end
        req_valid = 2'b11;
        #1;
        chk("midrst_tie_req0", {30'd0, if1.req_ready}, 32'd1);
        req_valid = 2'b00;
        sb.delete();
        sb_en = 1'b1;

`ifdef ALU_ARB_STATS_EN
        do_reset();
        issue(0, 3'd1, 8'd1, 8'd2, 16'd3, 1'b0, 1'b0);
        issue(1, 3'd1, 8'd1, 8'd1, 16'd0, 1'b0, 1'b1);
        issue(0, 3'd0, 8'd2, 8'd2, 16'd4, 1'b0, 1'b0);
        issue(1, 3'd2, 8'd3, 8'd3, 16'd9, 1'b0, 1'b0);
        issue(0, 3'd4, 8'd5, 8'd1, 16'd4, 1'b0, 1'b0);
        chk("stat_grant0", {16'd0, sg0}, 32'd3);
        chk("stat_grant1", {16'd0, sg1}, 32'd2);
        @(negedge clk);
        force dut1.stat_grant0 = 16'hFFFE;
        #1;
        release dut1.stat_grant0;
        for (int i = 0; i < 3; i++) issue(0, 3'd1, 8'd6, 8'd3, 16'd5, 1'b0, 1'b0);
        chk("stat_grant0_sat", {16'd0, sg0}, 32'h0000FFFF);
        chk("stat_grant1_hold", {16'd0, sg1}, 32'd2);
`endif

        chk("sb_final_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
